// File: rtl/ram_responder_pkg.sv
// Shared defaults and loader state encoding for the boot-loadable RAM responder.
package ram_responder_pkg;

  localparam int ADR_W_DEF  = 6;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } loader_state_t;

  // Boot stream sends the high byte first.
  function automatic logic [15:0] pack_word(input logic [7:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/ram_responder_sp.sv
// Single-port-write RAM with a registered synchronous read; contents survive reset.
module ram_sp #(
  parameter int ADR_W  = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_ce,
  input  logic              i_we,
  input  logic [ADR_W-1:0]  i_wadr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADR_W-1:0]  i_radr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2**ADR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage array write port, deliberately not reset.
  always_ff @(posedge clk) begin
    if (i_ce && i_we) begin
      r_mem[i_wadr] <= i_wdata;
    end
  end

  // Read register: holds its value unless a read is performed.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_ce && i_re) begin
      r_rdata <= r_mem[i_radr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_responder.sv
// CPU-facing RAM with a byte-stream boot loader that fills the whole memory
// image, high byte first, before handing the RAM back to the CPU.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int ADR_W  = ADR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADR_W-1:0]  adr,
  input  logic              enable_mem,
  input  logic              w_mem,
  input  logic [DATA_W-1:0] data_wr,
  output logic [DATA_W-1:0] data_rd,
  input  logic              boot,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              boot_done
);

  localparam logic [ADR_W-1:0] PTR_LAST = '1;
  localparam logic [ADR_W-1:0] PTR_ONE  = {{(ADR_W-1){1'b0}}, 1'b1};

  loader_state_t     r_state;
  logic [ADR_W-1:0]  r_ptr;
  logic [7:0]        r_hi;
  logic [7:0]        r_lo;
  logic              r_byte_ready;
  logic              r_boot_done;

  logic              w_ld_we;
  logic              w_cpu_wr;
  logic              w_re;
  logic              w_we;
  logic [ADR_W-1:0]  w_wadr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_rdata;

  // boot masks the CPU entirely, so loader and CPU never contend for the port.
  assign w_ld_we  = boot & (r_state == WRITE);
  assign w_cpu_wr = enable_mem & w_mem & ~boot;
  assign w_re     = enable_mem & ~w_mem & ~boot;
  assign w_word   = DATA_W'(pack_word(r_hi, r_lo));

  // Write-port mux between loader and CPU; nothing is written during reset.
  always_comb begin
    w_we    = 1'b0;
    w_wadr  = adr;
    w_wdata = data_wr;
    if (rst) begin
      w_we = 1'b0;
    end else if (w_ld_we) begin
      w_we    = 1'b1;
      w_wadr  = r_ptr;
      w_wdata = w_word;
    end else if (w_cpu_wr) begin
      w_we = 1'b1;
    end else begin
      w_we = 1'b0;
    end
  end

  // Loader FSM; handshake flags are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_hi         <= 8'h00;
      r_lo         <= 8'h00;
      r_byte_ready <= 1'b0;
      r_boot_done  <= 1'b0;
    end else if (ce) begin
      if (!boot) begin
        r_state      <= IDLE;
        r_byte_ready <= 1'b0;
        r_boot_done  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state      <= HI;
            r_ptr        <= '0;
            r_byte_ready <= 1'b1;
            r_boot_done  <= 1'b0;
          end
          HI: begin
            if (byte_valid) begin
              r_hi    <= byte_in;
              r_state <= LO;
            end
          end
          LO: begin
            if (byte_valid) begin
              r_lo         <= byte_in;
              r_state      <= WRITE;
              r_byte_ready <= 1'b0;
            end
          end
          WRITE: begin
            if (r_ptr == PTR_LAST) begin
              r_state     <= DONE;
              r_boot_done <= 1'b1;
            end else begin
              r_ptr        <= r_ptr + PTR_ONE;
              r_state      <= HI;
              r_byte_ready <= 1'b1;
            end
          end
          DONE: begin
            r_byte_ready <= 1'b0;
            r_boot_done  <= 1'b1;
          end
          default: begin
            r_state      <= IDLE;
            r_byte_ready <= 1'b0;
            r_boot_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  ram_sp #(
    .ADR_W  (ADR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_rst   (rst),
    .i_ce    (ce),
    .i_we    (w_we),
    .i_wadr  (w_wadr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_radr  (adr),
    .o_rdata (w_rdata)
  );

  assign data_rd    = w_rdata;
  assign byte_ready = r_byte_ready;
  assign boot_done  = r_boot_done;

endmodule
